// File: rtl/lsu_ctrl.sv
// Load/store unit: effective address, alignment checks, byte-enabled
// memory request/grant port and lane-extracted load response.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [1:0]  rsp_cause
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_MIS  = 2'b01;
    localparam logic [1:0] C_ILL  = 2'b10;
    localparam logic [1:0] C_TO   = 2'b11;

    state_t state;
    state_t state_nxt;

    logic [31:0] ea_q;
    logic [2:0]  f3_q;
    logic        st_q;
    logic [7:0]  cnt_q;

    logic [31:0] ea_d;
    logic [2:0]  f3_d;
    logic        st_d;
    logic [7:0]  cnt_d;

    logic        mem_req_d;
    logic        mem_we_d;
    logic [31:0] mem_addr_d;
    logic [3:0]  mem_be_d;
    logic [31:0] mem_wdata_d;
    logic        rsp_valid_d;
    logic [31:0] rsp_data_d;
    logic        rsp_err_d;
    logic [1:0]  rsp_cause_d;

    logic [31:0] ea_in;
    logic        illegal_in;
    logic        misal_in;
    logic        misal_only;
    logic        fault_in;
    logic [7:0]  cnt_inc;
    logic        to_hit;

    // Byte enables: one lane for bytes, two for halves, all four for words.
    function automatic logic [3:0] be_of(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic [3:0] be;
        unique case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data is replicated so every candidate lane carries it.
    function automatic logic [31:0] wdata_of(
        input logic [2:0]  f3,
        input logic [31:0] wd
    );
        logic [31:0] r;
        unique case (f3[1:0])
            2'b00:   r = {4{wd[7:0]}};
            2'b01:   r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Pick the addressed lane out of the read word and extend it.
    function automatic logic [31:0] load_ext(
        input logic [2:0]  f3,
        input logic [1:0]  off,
        input logic [31:0] rd
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rd[{off, 3'b000} +: 8];
        h = off[1] ? rd[31:16] : rd[15:0];
        unique case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    // Request decode: effective address and fault classification.
    always_comb begin
        ea_in = req_base + req_offset;
        if (req_store) begin
            illegal_in = req_funct3[2] | (&req_funct3[1:0]);
        end else begin
            illegal_in = (req_funct3 == 3'b011)
                       | (req_funct3[2:1] == 2'b11);
        end
        misal_in = ((req_funct3[1:0] == 2'b01) & ea_in[0])
                 | ((req_funct3[1:0] == 2'b10) & (|ea_in[1:0]));
        misal_only = misal_in & ~illegal_in;
        fault_in   = illegal_in | misal_in;
        cnt_inc    = cnt_q + 8'd1;
        to_hit     = (cnt_inc == TO_LIM);
    end

    assign req_ready = (state == IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = fault_in ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    state_nxt = st_q ? RESP : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (mem_rvalid || to_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and the latched request.
    always_comb begin
        ea_d        = ea_q;
        f3_d        = f3_q;
        st_d        = st_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_be_d    = mem_be;
        mem_wdata_d = mem_wdata;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;
        rsp_cause_d = rsp_cause;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    ea_d = ea_in;
                    f3_d = req_funct3;
                    st_d = req_store;
                    unique case (1'b1)
                        illegal_in: begin
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = ea_in;
                            rsp_err_d   = 1'b1;
                            rsp_cause_d = C_ILL;
                        end
                        misal_only: begin
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = ea_in;
                            rsp_err_d   = 1'b1;
                            rsp_cause_d = C_MIS;
                        end
                        default: begin
                            mem_req_d   = 1'b1;
                            mem_we_d    = req_store;
                            mem_addr_d  = {ea_in[31:2], 2'b00};
                            mem_be_d    = be_of(req_funct3, ea_in[1:0]);
                            mem_wdata_d = wdata_of(req_funct3, req_wdata);
                        end
                    endcase
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (st_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = 32'd0;
                        rsp_err_d   = 1'b0;
                        rsp_cause_d = C_NONE;
                    end else begin
                        cnt_d = 8'd0;
                    end
                end
            end
            WAIT_RD: begin
                if (mem_rvalid) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = load_ext(f3_q, ea_q[1:0], mem_rdata);
                    rsp_err_d   = 1'b0;
                    rsp_cause_d = C_NONE;
                    cnt_d       = 8'd0;
                end else if (to_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = ea_q;
                    rsp_err_d   = 1'b1;
                    rsp_cause_d = C_TO;
                    cnt_d       = 8'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = 32'd0;
                    rsp_err_d   = 1'b0;
                    rsp_cause_d = C_NONE;
                end
            end
            default: begin
                mem_req_d   = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Output and request-latch registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ea_q      <= 32'd0;
            f3_q      <= 3'd0;
            st_q      <= 1'b0;
            cnt_q     <= 8'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_err   <= 1'b0;
            rsp_cause <= 2'd0;
        end else begin
            ea_q      <= ea_d;
            f3_q      <= f3_d;
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_be    <= mem_be_d;
            mem_wdata <= mem_wdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            rsp_cause <= rsp_cause_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed plan steps plus random
// transactions against a byte-level memory/ISA reference model.
module tb_lsu_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [1:0]  rsp_cause;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_base   (req_base),
        .req_offset (req_offset),
        .req_wdata  (req_wdata),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .rsp_cause  (rsp_cause)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return mem[a[7:2]][8*int'(a[1:0]) +: 8];
    endfunction

    // One transaction: drive request, act as memory, check every cycle.
    task automatic txn(input logic st, input logic [2:0] f3,
                       input logic [31:0] base, input logic [31:0] off,
                       input logic [31:0] wd, input int gdly,
                       input int rdly, input int bpdly, input bit lost,
                       output logic [31:0] got);
        logic [31:0] ea, a, e_data, e_wd, mask;
        logic [3:0]  e_be;
        logic [1:0]  e_cause;
        int          n;
        bit          ill, mis;
        ea   = base + off;
        n    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mask = (n == 1) ? 32'hFF : (n == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        ill  = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis  = !ill && ((ea & 32'(n - 1)) != 32'd0);
        e_be = 4'd0;
        for (int k = 0; k < n; k++) e_be[(int'(ea[1:0]) + k) % 4] = 1'b1;
        for (int j = 0; j < 4; j++) e_wd[8*j +: 8] = wd[8*(j % n) +: 8];
        e_data  = 32'd0;
        e_cause = 2'd0;

        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_base   = base;
        req_offset = off;
        req_wdata  = wd;
        tick();
        req_valid  = 1'b0;
        req_base   = $urandom;
        req_offset = $urandom;
        req_wdata  = $urandom;

        if (ill || mis) begin
            chk("fault_no_req", {31'd0, mem_req}, 32'd0);
            e_data  = ea;
            e_cause = ill ? 2'b10 : 2'b01;
        end else begin
            for (int i = 0; i <= gdly; i++) begin
                chk("mem_req", {31'd0, mem_req}, 32'd1);
                chk("mem_we", {31'd0, mem_we}, {31'd0, st});
                chk("mem_addr", mem_addr, {ea[31:2], 2'b00});
                chk("mem_be", {28'd0, mem_be}, {28'd0, e_be});
                if (st) chk("mem_wdata", mem_wdata, e_wd);
                chk("rsp_early", {31'd0, rsp_valid}, 32'd0);
                mem_gnt = (i == gdly);
                tick();
            end
            mem_gnt = 1'b0;
            if (st) begin
                for (int k = 0; k < n; k++) begin
                    a = ea + 32'(k);
                    mem[a[7:2]][8*int'(a[1:0]) +: 8] = wd[8*k +: 8];
                end
            end else begin
                chk("req_dropped", {31'd0, mem_req}, 32'd0);
                for (int k = 0; k < n; k++)
                    e_data[8*k +: 8] = rd_byte(ea + 32'(k));
                if (!f3[2] && e_data[8*n-1]) e_data = e_data | ~mask;
                if (lost) begin
                    for (int i = 0; i < TO; i++) begin
                        chk("rsp_before_to", {31'd0, rsp_valid}, 32'd0);
                        tick();
                    end
                    e_data  = ea;
                    e_cause = 2'b11;
                end else begin
                    for (int i = 0; i < rdly; i++) begin
                        chk("rsp_before_rd", {31'd0, rsp_valid}, 32'd0);
                        tick();
                    end
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem[ea[7:2]];
                    tick();
                    mem_rvalid = 1'b0;
                    mem_rdata  = $urandom;
                end
            end
        end

        got = rsp_data;
        for (int i = 0; i <= bpdly; i++) begin
            chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("rsp_data", rsp_data, e_data);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e_cause != 2'd0});
            chk("rsp_cause", {30'd0, rsp_cause}, {30'd0, e_cause});
            chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
            rsp_ready = (i == bpdly);
            tick();
        end
        rsp_ready = 1'b0;
        chk("rsp_done", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] got, ea, off;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'd0;
        req_base   = 32'd0;
        req_offset = 32'd0;
        req_wdata  = 32'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        rsp_ready  = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;

        #12;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        mem[1] = 32'hDEADBEEF;
        txn(1'b0, 3'b010, 32'h100, 32'd4, 32'd0, 0, 0, 0, 1'b0, got);
        chk("lw_data", got, 32'hDEADBEEF);

        mem[0] = 32'h80FF_1234;
        txn(1'b0, 3'b000, 32'h200, 32'd3, 32'd0, 0, 0, 0, 1'b0, got);
        chk("lb_data", got, 32'hFFFFFF80);
        txn(1'b0, 3'b100, 32'h200, 32'd3, 32'd0, 0, 1, 0, 1'b0, got);
        chk("lbu_data", got, 32'h00000080);

        txn(1'b1, 3'b001, 32'h10, 32'd2, 32'hAAAA5678, 3, 0, 0, 1'b0, got);
        chk("sh_data", got, 32'd0);
        txn(1'b0, 3'b101, 32'h10, 32'd2, 32'd0, 0, 0, 0, 1'b0, got);
        chk("lhu_after_sh", got, 32'h00005678);

        txn(1'b0, 3'b010, 32'h100, 32'd2, 32'd0, 0, 0, 0, 1'b0, got);
        chk("lw_mis_ea", got, 32'h102);
        txn(1'b1, 3'b100, 32'h100, 32'd1, 32'd0, 0, 0, 0, 1'b0, got);
        chk("st_ill_ea", got, 32'h101);
        txn(1'b0, 3'b010, 32'hFFFFFFFC, 32'd8, 32'd0, 0, 0, 0, 1'b0, got);
        chk("wrap_lw", got, 32'hDEADBEEF);

        txn(1'b0, 3'b010, 32'h0, 32'h20, 32'd0, 0, 0, 0, 1'b1, got);
        chk("timeout_ea", got, 32'h20);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("late_rvalid_ign", {31'd0, rsp_valid}, 32'd0);
            chk("late_rvalid_rdy", {31'd0, req_ready}, 32'd1);
        end
        mem_rvalid = 1'b0;
        txn(1'b0, 3'b010, 32'h0, 32'h4, 32'd0, 1, 2, 0, 1'b0, got);
        chk("after_timeout", got, 32'hDEADBEEF);

        txn(1'b0, 3'b001, 32'h200, 32'd2, 32'd0, 0, 0, 5, 1'b0, got);
        chk("bp_lh", got, 32'hFFFF80FF);

        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_base   = 32'h40;
        req_offset = 32'd0;
        tick();
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_addr", mem_addr, 32'd0);
        chk("rst_mid_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mid_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mid_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_rel_ready", {31'd0, req_ready}, 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            tick();
            mem_rvalid = 1'b0;
            chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end

        for (int t = 0; t < 150; t++) begin
            ea  = 32'($urandom_range(0, 255));
            off = $urandom;
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                ea - off, off, $urandom,
                $urandom_range(0, 3), $urandom_range(0, TO - 1),
                $urandom_range(0, 2), ($urandom_range(0, 15) == 0), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
